// File: rtl/sine_monitor.sv
// sine_monitor: measures period (in valid samples) and signed peaks between rising
// hysteresis crossings. Define SINE_MON_TIMEOUT_EN to add the MAX_PERIOD timeout pulse.
module sine_monitor #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned HYST       = 1024,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MAX_PERIOD = 1000000
) (
  input  logic                     clk_100,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     meas_valid,
  output logic        [CNT_W-1:0]  period,
  output logic signed [DATA_W-1:0] peak_max,
  output logic signed [DATA_W-1:0] peak_min,
  output logic                     locked,
  output logic                     overflow
`ifdef SINE_MON_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam logic signed [DATA_W-1:0] HystHi = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HystLo = -HystHi;
  localparam logic        [CNT_W-1:0]  CntMax = '1;

  typedef enum logic [2:0] {StSeek, StNeg, StPosFirst, StNegTrk, StPosTrk} state_e;

  state_e                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic signed [DATA_W-1:0]  run_max_q, run_max_d, run_min_q, run_min_d;
  logic                      meas_valid_q, meas_valid_d, locked_q, locked_d;
  logic                      overflow_q, overflow_d;
  logic        [CNT_W-1:0]   period_q, period_d;
  logic signed [DATA_W-1:0]  peak_max_q, peak_max_d, peak_min_q, peak_min_d;
  logic                      is_low, is_high, tracking, rise;
`ifdef SINE_MON_TIMEOUT_EN
  logic                      timeout_q, timeout_d;
`endif

  assign is_low   = sample_valid && (sample <= HystLo);
  assign is_high  = sample_valid && (sample >= HystHi);
  assign tracking = (state_q == StPosFirst) || (state_q == StNegTrk) || (state_q == StPosTrk);
  assign rise     = is_high && (state_q == StNegTrk);
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    overflow_d   = overflow_q;
    period_d     = period_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
`ifdef SINE_MON_TIMEOUT_EN
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      StSeek: if (is_low) state_d = StNeg;
      StNeg: begin
        if (is_high) begin
          state_d   = StPosFirst;
          cnt_d     = CNT_W'(1);
          run_max_d = sample;
          run_min_d = sample;
        end
      end
      StPosFirst, StPosTrk: if (is_low) state_d = StNegTrk;
      StNegTrk: if (is_high) state_d = StPosTrk;
      default: state_d = StSeek;
    endcase

    // The rising-event sample closes the old interval and opens the next one.
    if (tracking && sample_valid) begin
      if (rise) begin
        meas_valid_d = 1'b1;
        locked_d     = 1'b1;
        period_d     = cnt_q;
        overflow_d   = (cnt_q == CntMax);
        peak_max_d   = run_max_q;
        peak_min_d   = run_min_q;
        cnt_d        = CNT_W'(1);
        run_max_d    = sample;
        run_min_d    = sample;
      end else begin
        cnt_d = cnt_inc;
        if (sample > run_max_q) run_max_d = sample;
        if (sample < run_min_q) run_min_d = sample;
      end
    end

`ifdef SINE_MON_TIMEOUT_EN
    if (tracking && (cnt_q == CNT_W'(MAX_PERIOD)) && !rise) begin
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      state_d   = StSeek;
      cnt_d     = '0;
    end
`endif
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q      <= StSeek;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
      period_q     <= '0;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
`ifdef SINE_MON_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      overflow_q   <= overflow_d;
      period_q     <= period_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
`ifdef SINE_MON_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign overflow   = overflow_q;
  assign period     = period_q;
  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
`ifdef SINE_MON_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule
